// File: rtl/key_conditioner.sv
// key_conditioner: per-key 2-flop sync, tick debounce, press/release pulses and optional hold-to-repeat
// Ports: CP board clock, CR async active-low reset, KEY_IN raw key levels,
//        KEY_LEVEL debounced level (1 = pressed), KEY_PULSE press/repeat pulse,
//        KEY_RELEASE release pulse, KEY_ANY OR of KEY_LEVEL.
// Define KEY_AUTO_REPEAT_EN to build hold-to-repeat for the keys selected by REPEAT_MASK.
module key_conditioner #(
    parameter int                N_KEYS         = 9,
    parameter int                TICK_DIV       = 50000,
    parameter int                DEB_TICKS      = 20,
    parameter int                REPEAT_DELAY   = 500,
    parameter int                REPEAT_PERIOD  = 100,
    parameter logic [N_KEYS-1:0] REPEAT_MASK    = N_KEYS'(9'b000111111),
    parameter bit                KEY_ACTIVE_LOW = 1'b1
) (
    input  logic              CP,
    input  logic              CR,
    input  logic [N_KEYS-1:0] KEY_IN,
    output logic [N_KEYS-1:0] KEY_LEVEL,
    output logic [N_KEYS-1:0] KEY_PULSE,
    output logic [N_KEYS-1:0] KEY_RELEASE,
    output logic              KEY_ANY
);
    localparam int MAXT = DEB_TICKS > REPEAT_DELAY ?
                          (DEB_TICKS > REPEAT_PERIOD ? DEB_TICKS : REPEAT_PERIOD) :
                          (REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD);
    localparam int CW = $clog2(MAXT + 1);
    localparam int DW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] DEB_C = CW'(DEB_TICKS);
`ifdef KEY_AUTO_REPEAT_EN
    localparam logic [CW-1:0] DLY_C = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0] PER_C = CW'(REPEAT_PERIOD);
`endif

    typedef enum logic [2:0] {IDLE, PRESS_WAIT, HELD, REPEAT, RELEASE_WAIT} state_t;

    logic [DW-1:0]     div;
    logic              tick;
    logic [N_KEYS-1:0] s1, raw;

    assign tick = div == DW'(TICK_DIV - 1);

    always_ff @(posedge CP or negedge CR)
        if (!CR) div <= '0;
        else div <= tick ? '0 : div + 1'b1;

    // Synchronizers reset to "released" so coming out of reset never looks like a press
    always_ff @(posedge CP or negedge CR)
        if (!CR) begin
            s1  <= '0;
            raw <= '0;
        end else begin
            s1  <= KEY_ACTIVE_LOW ? ~KEY_IN : KEY_IN;
            raw <= s1;
        end

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        state_t        st, st_n;
        logic [CW-1:0] cnt, cnt_n, cnt_inc;
        logic          lvl, lvl_n, pls, pls_n, rel, rel_n;
        assign cnt_inc = cnt == '1 ? cnt : cnt + 1'b1;
`ifdef KEY_AUTO_REPEAT_EN
        logic [CW-1:0] rpt, rpt_n, rpt_inc;
        logic          from_rpt, from_rpt_n;
        assign rpt_inc = rpt == '1 ? rpt : rpt + 1'b1;
`endif

        always_ff @(posedge CP or negedge CR)
            if (!CR) begin
                st  <= IDLE;
                cnt <= '0;
                lvl <= 1'b0;
                pls <= 1'b0;
                rel <= 1'b0;
`ifdef KEY_AUTO_REPEAT_EN
                rpt      <= '0;
                from_rpt <= 1'b0;
`endif
            end else begin
                st  <= st_n;
                cnt <= cnt_n;
                lvl <= lvl_n;
                pls <= pls_n;
                rel <= rel_n;
`ifdef KEY_AUTO_REPEAT_EN
                rpt      <= rpt_n;
                from_rpt <= from_rpt_n;
`endif
            end

        always_comb begin
            st_n  = st;
            cnt_n = cnt;
            lvl_n = lvl;
            pls_n = 1'b0;
            rel_n = 1'b0;
`ifdef KEY_AUTO_REPEAT_EN
            rpt_n      = rpt;
            from_rpt_n = from_rpt;
`endif
            if (tick) begin
                case (st)
                    IDLE: if (raw[i]) begin
                        st_n  = PRESS_WAIT;
                        cnt_n = CW'(1);
                    end
                    PRESS_WAIT:
                        if (!raw[i]) st_n = IDLE;
                        else if (cnt_inc >= DEB_C) begin
                            st_n  = HELD;
                            lvl_n = 1'b1;
                            pls_n = 1'b1;
`ifdef KEY_AUTO_REPEAT_EN
                            rpt_n = '0;
`endif
                        end else cnt_n = cnt_inc;
                    HELD:
                        if (!raw[i]) begin
                            st_n  = RELEASE_WAIT;
                            cnt_n = CW'(1);
`ifdef KEY_AUTO_REPEAT_EN
                            from_rpt_n = 1'b0;
                        end else if (REPEAT_MASK[i]) begin
                            if (rpt_inc >= DLY_C) begin
                                st_n  = REPEAT;
                                pls_n = 1'b1;
                                rpt_n = '0;
                            end else rpt_n = rpt_inc;
`endif
                        end
`ifdef KEY_AUTO_REPEAT_EN
                    REPEAT:
                        if (!raw[i]) begin
                            st_n       = RELEASE_WAIT;
                            cnt_n      = CW'(1);
                            from_rpt_n = 1'b1;
                        end else if (rpt_inc >= PER_C) begin
                            pls_n = 1'b1;
                            rpt_n = '0;
                        end else rpt_n = rpt_inc;
`endif
                    // A press seen here is bounce: resume the held state silently
                    RELEASE_WAIT:
                        if (raw[i]) begin
`ifdef KEY_AUTO_REPEAT_EN
                            st_n  = from_rpt ? REPEAT : HELD;
                            rpt_n = '0;
`else
                            st_n = HELD;
`endif
                        end else if (cnt_inc >= DEB_C) begin
                            st_n  = IDLE;
                            lvl_n = 1'b0;
                            rel_n = 1'b1;
                        end else cnt_n = cnt_inc;
                    default: st_n = IDLE;
                endcase
            end
        end

        assign KEY_LEVEL[i]   = lvl;
        assign KEY_PULSE[i]   = pls;
        assign KEY_RELEASE[i] = rel;
    end

    assign KEY_ANY = |KEY_LEVEL;
endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: directed checks of debounce, pulses, repeat, glitch and reset behaviour
module tb_key_conditioner;
    logic       clk = 1'b0;
    logic       cr = 1'b0;
    logic [8:0] key_in = '1;
    logic [8:0] level, pulse, rel;
    logic       key_any;
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         pcnt[9] = '{default: 0};
    int         rcnt[9] = '{default: 0};
    int         plast[9] = '{default: 0};
    int         pprev[9] = '{default: 0};

    key_conditioner #(
        .N_KEYS(9), .TICK_DIV(4), .DEB_TICKS(3), .REPEAT_DELAY(10), .REPEAT_PERIOD(4),
        .REPEAT_MASK(9'b000111111), .KEY_ACTIVE_LOW(1'b1)
    ) dut (
        .CP(clk), .CR(cr), .KEY_IN(key_in), .KEY_LEVEL(level),
        .KEY_PULSE(pulse), .KEY_RELEASE(rel), .KEY_ANY(key_any)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        for (int k = 0; k < 9; k++) begin
            if (pulse[k]) begin
                pcnt[k]  <= pcnt[k] + 1;
                pprev[k] <= plast[k];
                plast[k] <= cyc;
            end
            if (rel[k]) rcnt[k] <= rcnt[k] + 1;
        end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chkr(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert ((obs >= lo && obs <= hi) === 1'b1) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic wait_ev(input int k, input bit on_rel, input int bound, output int at);
        at = -1;
        for (int n = 0; n < bound; n++) begin
            @(negedge clk);
            if (on_rel ? rel[k] : pulse[k]) begin
                at = cyc;
                break;
            end
        end
    endtask

    initial begin
        int n0, at, p0, p1, r0, r1, g, sp, sr;
        repeat (5) @(negedge clk);
        chk("rst_level", int'(level), 0);
        chk("rst_pulse", int'(pulse), 0);
        chk("rst_release", int'(rel), 0);
        chk("rst_any", int'(key_any), 0);
        cr = 1'b1;
        repeat (100) @(negedge clk);
        sp = 0;
        sr = 0;
        for (int k = 0; k < 9; k++) begin
            sp += pcnt[k];
            sr += rcnt[k];
        end
        chk("idle_pulses", sp, 0);
        chk("idle_releases", sr, 0);

        // clean press on key 0, held 30 ticks
        p0 = pcnt[0];
        n0 = cyc;
        key_in[0] = 1'b0;
        wait_ev(0, 1'b0, 40, at);
        chkr("press_lat0", at - n0, 11, 14);
        chk("level0", int'(level[0]), 1);
        chk("any0", int'(key_any), 1);
        repeat (n0 + 120 - cyc) @(negedge clk);
`ifdef KEY_AUTO_REPEAT_EN
        chk("pulses0", pcnt[0] - p0, 6);
        chk("span0", plast[0] - at, 104);
        chk("period0", plast[0] - pprev[0], 16);
`else
        chk("pulses0", pcnt[0] - p0, 1);
`endif
        r0 = rcnt[0];
        n0 = cyc;
        key_in[0] = 1'b1;
        wait_ev(0, 1'b1, 40, at);
        chkr("rel_lat0", at - n0, 11, 14);
        chk("rel_level0", int'(level[0]), 0);
        chk("rel_any", int'(key_any), 0);
        repeat (4) @(negedge clk);
        chk("rel_count0", rcnt[0] - r0, 1);

        // bounce on key 1: one toggle per tick for 10 ticks
        p0 = pcnt[1];
        r0 = rcnt[1];
        for (int t = 0; t < 10; t++) begin
            key_in[1] = ~key_in[1];
            repeat (4) @(negedge clk);
        end
        repeat (40) @(negedge clk);
        chk("bounce_pulses", pcnt[1] - p0, 0);
        chk("bounce_level", int'(level[1]), 0);
        chk("bounce_rel", rcnt[1] - r0, 0);

        // non-repeat key 8 held 40 ticks
        p0 = pcnt[8];
        key_in[8] = 1'b0;
        repeat (160) @(negedge clk);
        chk("pulses8", pcnt[8] - p0, 1);
        chk("level8", int'(level[8]), 1);
        key_in[8] = 1'b1;
        wait_ev(8, 1'b1, 40, at);
        chk("rel8_seen", int'(at > 0), 1);

        // simultaneous press on keys 2 and 5
        p0 = pcnt[2];
        p1 = pcnt[5];
        key_in[2] = 1'b0;
        key_in[5] = 1'b0;
        wait_ev(2, 1'b0, 40, at);
        chk("simul_pulse5", int'(pulse[5]), 1);
        repeat (28) @(negedge clk);
        chk("simul_last", plast[2] - plast[5], 0);
        chk("simul_count", (pcnt[2] - p0) * 10 + (pcnt[5] - p1), 11);
        key_in[2] = 1'b1;
        key_in[5] = 1'b1;
        repeat (30) @(negedge clk);
        chk("simul_released", int'(level[2] | level[5]), 0);

        // one-tick release glitch on key 3
        p0 = pcnt[3];
        r0 = rcnt[3];
        key_in[3] = 1'b0;
        wait_ev(3, 1'b0, 40, at);
`ifdef KEY_AUTO_REPEAT_EN
        wait_ev(3, 1'b0, 50, at);
        g = at;
        key_in[3] = 1'b1;
        repeat (4) @(negedge clk);
        key_in[3] = 1'b0;
        wait_ev(3, 1'b0, 40, at);
        chk("glitch_next3", at - g, 24);
`else
        repeat (20) @(negedge clk);
        key_in[3] = 1'b1;
        repeat (4) @(negedge clk);
        key_in[3] = 1'b0;
        repeat (40) @(negedge clk);
        chk("glitch_pulses3", pcnt[3] - p0, 1);
`endif
        chk("glitch_level3", int'(level[3]), 1);
        r1 = rcnt[3];
        chk("glitch_rel3", r1 - r0, 0);
        key_in[3] = 1'b1;
        wait_ev(3, 1'b1, 40, at);
        chk("rel3_seen", int'(at > 0), 1);
        repeat (8) @(negedge clk);

        // reset in the middle of key 4's press debounce
        p0 = pcnt[4];
        key_in[4] = 1'b0;
        repeat (8) @(negedge clk);
        chk("pw_no_pulse4", pcnt[4] - p0, 0);
        cr = 1'b0;
        @(negedge clk);
        chk("mid_rst_level", int'(level), 0);
        chk("mid_rst_pulse", int'(pulse), 0);
        chk("mid_rst_any", int'(key_any), 0);
        repeat (2) @(negedge clk);
        n0 = cyc;
        cr = 1'b1;
        wait_ev(4, 1'b0, 40, at);
        chk("rst_relat4", at - n0, 12);
        key_in[4] = 1'b1;
        wait_ev(4, 1'b1, 40, at);
        chk("rel4_seen", int'(at > 0), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
